// File: rtl/led_sequencer.sv
// led_sequencer: CPU-programmed four-slot LED pattern player.
// Each slot is written once and then held for max(PERIOD,1) ticks of PRESCALE clocks.
module led_sequencer #(
  parameter int PRESCALE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_we,
  input  logic       cpu_re,
  input  logic [2:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic [7:0] cpu_rdata,
  output logic       led_we,
  output logic [7:0] led_wdata,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, WRITE, HOLD, DONE} state_t;
  state_t      r_state, w_next;
  logic [7:0]  r_ctrl, r_period, r_hold;
  logic [7:0]  r_pat [4];
  logic [1:0]  r_idx;
  logic [15:0] r_pre;
  logic [7:0]  r_tick;
  logic        r_done, r_abort, w_abort;
  logic        w_ctrl_wr, w_stop, w_tick_end, w_hold_end;
  logic [7:0]  w_rd;
  assign w_ctrl_wr  = cpu_we && cpu_addr == 3'd0;
  assign w_stop     = !r_ctrl[0];
  assign w_tick_end = r_pre == 16'(PRESCALE - 1);
  assign w_hold_end = w_tick_end && r_tick == r_hold - 8'd1;
  assign busy       = r_state == WRITE || r_state == HOLD;
  assign led_we     = r_state == WRITE || r_abort;
  assign led_wdata  = r_state == WRITE ? r_pat[r_idx] : 8'h00;
  always_comb begin
    w_next  = r_state;
    w_abort = 1'b0;
    case (r_state)
      IDLE:  w_next = (r_ctrl[0] && !r_abort) ? WRITE : IDLE;
      WRITE: begin
        w_abort = w_stop;
        w_next  = w_stop ? IDLE : HOLD;
      end
      HOLD:  begin
        w_abort = w_stop;
        w_next  = w_stop ? IDLE : !w_hold_end ? HOLD : (r_idx != 2'd3 || r_ctrl[1]) ? WRITE : DONE;
      end
      DONE:  w_next = w_ctrl_wr ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    w_rd = 8'h00;
    if (cpu_addr[2])
      w_rd = r_pat[cpu_addr[1:0]];
    else
      w_rd = cpu_addr[1:0] == 2'd0 ? r_ctrl :
             cpu_addr[1:0] == 2'd1 ? r_period :
             cpu_addr[1:0] == 2'd2 ? {4'h0, r_idx, r_done, busy} : 8'h00;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_abort <= 1'b0;
    end else begin
      r_state <= w_next;
      r_abort <= w_abort;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctrl    <= 8'h00;
      r_period  <= 8'h00;
      r_hold    <= 8'h01;
      for (int i = 0; i < 4; i++) r_pat[i] <= 8'h00;
      r_idx     <= 2'd0;
      r_pre     <= 16'd0;
      r_tick    <= 8'd0;
      r_done    <= 1'b0;
      cpu_rdata <= 8'h00;
    end else begin
      if (cpu_re) cpu_rdata <= w_rd;
      if (cpu_we) begin
        if (cpu_addr == 3'd0) r_ctrl <= {6'd0, cpu_wdata[1:0]};
        if (cpu_addr == 3'd1) r_period <= cpu_wdata;
        if (cpu_addr[2]) r_pat[cpu_addr[1:0]] <= cpu_wdata;
      end
      r_done <= (r_state == HOLD && w_next == DONE) ? 1'b1 :
                (w_ctrl_wr || (r_state == IDLE && w_next == WRITE)) ? 1'b0 : r_done;
      if (w_abort || r_state == IDLE || w_next == DONE)
        r_idx <= 2'd0;
      else if (r_state == HOLD && w_next == WRITE)
        r_idx <= r_idx + 2'd1;
      if (r_state == WRITE) begin
        r_pre  <= 16'd0;
        r_tick <= 8'd0;
        r_hold <= r_period == 8'd0 ? 8'd1 : r_period;
      end else if (r_state == HOLD) begin
        r_pre <= w_tick_end ? 16'd0 : r_pre + 16'd1;
        if (w_tick_end) r_tick <= r_tick + 8'd1;
      end
    end
  end
endmodule

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 Parameter: PRESCALE, 16, number of clk cycles per sequencer tick (legal range 1..65535).
REQ-002 Port: clk  input  1  clock; all state updates on the rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: cpu_we  input  1  CPU register write strobe, sampled on a rising clk edge.
REQ-005 Port: cpu_re  input  1  CPU register read strobe.
REQ-006 Port: cpu_addr  input  3  register select: 0 CTRL, 1 PERIOD, 2 STATUS, 4-7 PATTERN[0..3].
REQ-007 Port: cpu_wdata  input  8  CPU write data.
REQ-008 Port: cpu_rdata  output  8  registered read data.
REQ-009 Port: led_we  output  1  write strobe to the LED register peripheral.
REQ-010 Port: led_wdata  output  8  data to the LED register peripheral.
REQ-011 Port: busy  output  1  high while the sequence is running (states WRITE or HOLD).

Function
REQ-012 CTRL layout: bit0 enable, bit1 loop, bits 7:2 read as 0; PERIOD is 8-bit tick count; PATTERN[n] are 8-bit LED values.
REQ-013 STATUS layout: bit0 busy, bit1 done (sticky), bits 3:2 current slot index, bits 7:4 read as 0; writes to STATUS and to address 3 are ignored.
REQ-014 Read: when cpu_re is high, cpu_rdata shall show the addressed register one cycle later; otherwise cpu_rdata holds its value.
REQ-015 FSM states: IDLE, WRITE, HOLD, DONE.
REQ-016 IDLE: when CTRL.enable = 1, the FSM goes to WRITE with slot index 0 and done cleared.
REQ-017 WRITE: lasts exactly one cycle, with led_we = 1 and led_wdata = PATTERN[index]; the tick counter loads to zero; the next state is HOLD.
REQ-018 HOLD: a prescaler counts PRESCALE clk cycles per tick; HOLD lasts PERIOD ticks, and PERIOD = 0 counts as 1.
REQ-019 End of HOLD when index < 3: index increments and the FSM goes to WRITE.
REQ-020 End of HOLD when index = 3 and loop = 1: index wraps to 0 and the FSM goes to WRITE.
REQ-021 End of HOLD when index = 3 and loop = 0: the FSM goes to DONE and done sets.
REQ-022 DONE: LEDs keep the last pattern and busy = 0; a CPU write to CTRL with enable = 1 restarts from slot 0 (via IDLE); enable = 0 goes to IDLE; done stays set until CTRL is written.
REQ-023 Abort: if CTRL.enable goes to 0 in WRITE or HOLD, the next cycle drives led_we = 1 with led_wdata = 0x00 (LEDs off), then the FSM goes to IDLE with index reset to 0.
REQ-024 A PATTERN write during a run does not affect the current HOLD; it takes effect at the next WRITE of that slot.
REQ-025 A PERIOD write during HOLD takes effect at the next WRITE.
REQ-026 The full clk-cycle spacing between successive led_we pulses is 1 + max(PERIOD,1) x PRESCALE.
REQ-027 A simultaneous cpu_we and cpu_re to the same address shall return the old value and then store the new value.
REQ-028 led_we shall never be high for two consecutive cycles except for WRITE followed by abort.

Reset
REQ-029 When reset is high, state shall be IDLE; CTRL, PERIOD and PATTERN[0..3] = 0x00; index, prescaler and tick counter = 0; done = 0.
REQ-030 When reset is high, outputs shall be: led_we = 0, led_wdata = 0x00, cpu_rdata = 0x00, busy = 0.
REQ-031 Reset asserted mid-sequence shall abort at once with no LED-off write; the LED peripheral is reset by its own reset.

Verification
REQ-032 Run with no loop: PRESCALE = 2, PATTERN = 01/02/04/08, PERIOD = 3, CTRL = 01 -> four led_we pulses 7 cycles apart carrying 01, 02, 04, 08; then STATUS reads 0x02 (done, not busy).
REQ-033 Loop: CTRL = 03 -> after 08, the next pulse is 01 (wrap-around) and busy stays high.
REQ-034 Abort: write CTRL = 00 during HOLD -> one led_we pulse with 0x00, then IDLE and busy = 0.
REQ-035 PERIOD = 0 -> behaves exactly like PERIOD = 1 (pulse spacing 1 + PRESCALE).
REQ-036 Write PATTERN[2] = AA while slot 1 is held -> the slot-2 pulse carries AA.
REQ-037 Assert reset during HOLD -> all outputs 0 at once, with no further led_we; after release, STATUS reads 0x00.
